// File: rtl/uart_hex_tx.sv
// uart_hex_tx -- sends a 256-bit SHA-256 digest over a UART line as 64 lowercase
// ASCII hex characters, most significant nibble first. Each character is an 8N1 frame:
// one start bit, 8 data bits LSB first, one stop bit. Frames follow each other with
// no idle gap.
//
// Optional feature: define HEX_TX_CRLF_EN to append CR (0x0D) and LF (0x0A) after the
// hex characters, giving 66 characters in total. Without it, 64 characters are sent.
//
// Handshake: start is a level request with no ready signal. It is sampled only while
// idle. Raising it at a rising edge in IDLE latches digest and begins a transmission.
// Requests made while busy are dropped, not queued. done pulses for one cycle when the
// final stop bit ends. busy is already low in that cycle, so a start seen at the next
// edge begins a new transmission immediately.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   digest[255:0] in  value to transmit (bit 255 = most significant)
//   start        in   transmit request, honoured only in IDLE
//   busy         out  high while a transmission is in progress
//   done         out  one-cycle pulse after the last stop bit
//   TX           out  UART serial line, idle high
//   dbg_state_o  out  FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module uart_hex_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] digest,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         TX,
  output logic [1:0]   dbg_state_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef HEX_TX_CRLF_EN
  localparam logic [6:0] LAST_CHAR = 7'd65;
`else
  localparam logic [6:0] LAST_CHAR = 7'd63;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      char_q, char_d;
  logic [255:0]    sh_q, sh_d;       // latched digest; current nibble lives in [255:252]
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic [7:0]      byte_d;
  logic            baud_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};  // 0x57 + 10 = 'a'
  endfunction

`ifdef HEX_TX_CRLF_EN
  function automatic logic [7:0] char_byte(input logic [3:0] nib, input logic [6:0] idx);
    if (idx == 7'd64)      return 8'h0D;
    else if (idx == 7'd65) return 8'h0A;
    else                   return hex_ascii(nib);
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    char_d   = char_q;
    sh_d     = sh_q;
    done_d   = 1'b0;
    tx_d     = 1'b1;
    baud_end = (baud_q == BAUD_LAST);

    // The baud counter free-runs across all bit periods of a transmission,
    // wrapping at the end of each bit so consecutive bits abut exactly.
    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          sh_d    = digest;
          baud_d  = '0;
          bit_d   = '0;
          char_d  = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          bit_d = bit_q + 1'b1;  // wraps back to 0 after bit 7
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (char_q == LAST_CHAR) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            char_d  = '0;
          end else begin
            state_d = S_START;
            char_d  = char_q + 1'b1;
            sh_d    = {sh_q[251:0], 4'h0};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // TX is registered and derived from the next state, so the line changes
    // on the same edge as the state and stays glitch-free.
`ifdef HEX_TX_CRLF_EN
    byte_d = char_byte(sh_d[255:252], char_d);
`else
    byte_d = hex_ascii(sh_d[255:252]);
`endif
    case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = byte_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign TX          = tx_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
`timescale 1ns/1ps
module tb_uart_hex_tx;

  localparam int CPB = 4;
`ifdef HEX_TX_CRLF_EN
  localparam int NCH = 66;
`else
  localparam int NCH = 64;
`endif
  localparam int FRAME     = 10 * CPB;
  localparam int TX_CYCLES = NCH * FRAME;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] digest = '0;
  logic         busy, done, TX;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit rst_seen = 1'b0;

  uart_hex_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .digest(digest), .start(start),
    .busy(busy), .done(done), .TX(TX), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge rst) rst_seen = 1'b1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the character stream is the digest printed as lowercase hex,
  // most significant nibble first, optionally followed by CR LF.
  function automatic void model_push(input logic [255:0] d);
    string hexdig = "0123456789abcdef";
    for (int i = 0; i < 64; i++) begin
      int nib = int'((d >> (4 * (63 - i))) & 256'hf);
      exp_q.push_back(8'(hexdig[nib]));
    end
`ifdef HEX_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  task automatic check_stream(input string name);
    int n;
    check({name, " rx_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", name, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // ---------------- UART receiver (bench side) ----------------
  initial begin : rx_mon
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge clk);
      if (TX === 1'b0 && !rst) begin
        rst_seen = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        ok = (TX === 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = TX;
        end
        repeat (CPB) @(negedge clk);
        ok = ok && (TX === 1'b1);
        if (!rst_seen) begin
          check("rx framing", 64'(ok), 64'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the first falling edge after the start was sampled (cycle 0 of the frame).
  task automatic launch(input logic [255:0] d, input bit expect_it);
    @(negedge clk);
    digest = d;
    start  = 1'b1;
    if (expect_it) model_push(d);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_tx(input string name, input int t0);
    int t = t0;
    int busy_cnt = 0;
    int lat = -1;
    int dn = 0;
    bit quiet = 1'b1;
    while (lat < 0 && t < TX_CYCLES + 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = t;
        dn++;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    check({name, " done_latency"}, 64'(lat), 64'(TX_CYCLES));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(TX_CYCLES - t0));
    check({name, " busy_at_done"}, 64'(busy), 64'd0);
    check({name, " tx_at_done"}, 64'(TX), 64'd1);
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (busy !== 1'b0 || TX !== 1'b1) quiet = 1'b0;
    end
    check({name, " done_pulses"}, 64'(dn), 64'd1);
    check({name, " idle_after"}, 64'(quiet), 64'd1);
  endtask

  task automatic abort_and_idle(input string name);
    bit quiet = 1'b1;
    check({name, " busy_before_rst"}, 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check({name, " tx_in_rst"}, 64'(TX), 64'd1);
    check({name, " busy_in_rst"}, 64'(busy), 64'd0);
    check({name, " done_in_rst"}, 64'(done), 64'd0);
    check({name, " state_in_rst"}, 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
    end
    check({name, " idle_after_rst"}, 64'(quiet), 64'd1);
    rx_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [255:0] rand_digest();
    logic [255:0] d = '0;
    for (int i = 0; i < 8; i++) d = {d[223:0], 32'($urandom)};
    return d;
  endfunction

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [255:0] d;
    logic [7:0]   first;
    logic [7:0]   last_hex;
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    logic [255:0] d;
    logic [9:0] exp_bits;
    int t;
    bit fin;

    vecs[0] = '{{4{64'h0123456789abcdef}}, 8'h30, 8'h66};
    vecs[1] = '{{256{1'b1}}, 8'h66, 8'h66};
    vecs[2] = '{256'h0, 8'h30, 8'h30};
    vecs[3] = '{{4'ha, 248'h0, 4'h5}, 8'h61, 8'h35};

    // reset
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", 64'(TX), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle tx", 64'(TX), 64'd1);

    // table vectors
    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].d, 1'b1);
      finish_tx($sformatf("vec%0d", v), 0);
      check($sformatf("vec%0d first", v), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, vecs[v].first);
      check($sformatf("vec%0d last_hex", v), (rx_q.size() > 63) ? rx_q[63] : 8'hxx, vecs[v].last_hex);
      check_stream($sformatf("vec%0d", v));
    end

    // random digests; digest input scrambled right after latching
    for (int r = 0; r < 3; r++) begin
      launch(rand_digest(), 1'b1);
      digest = rand_digest();
      finish_tx($sformatf("rand%0d", r), 0);
      check_stream($sformatf("rand%0d", r));
    end

    // first character 0x30: line samples at bit centres, then reset mid-frame
    launch({4'h0, rand_digest() >> 4}, 1'b0);
    exp_bits = 10'b1001100000;
    repeat (CPB / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bit_centre%0d", k), 64'(TX), 64'(exp_bits[k]));
      if (k < 9) repeat (CPB) @(negedge clk);
    end
    abort_and_idle("abort_char0");

    // reset during data bit 2 of character 5
    launch(rand_digest(), 1'b0);
    repeat (5 * FRAME + CPB + 2 * CPB + 1) @(negedge clk);
    abort_and_idle("abort_char5");

    // a fresh transmission after reset starts cleanly
    launch(rand_digest(), 1'b1);
    finish_tx("post_rst", 0);
    check_stream("post_rst");

    // start re-pulsed and digest zeroed during character 10: both ignored
    d = rand_digest();
    launch(d, 1'b1);
    repeat (10 * FRAME) @(negedge clk);
    digest = '0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_tx("midstart", 10 * FRAME + 1);
    check_stream("midstart");

    // start held high: back-to-back transmissions with a one-cycle gap
    d = rand_digest();
    @(negedge clk);
    digest = d;
    start  = 1'b1;
    model_push(d);
    model_push(d);
    @(negedge clk);
    t = 0;
    fin = 1'b0;
    while (!fin && t < TX_CYCLES + 100) begin
      if (done === 1'b1) fin = 1'b1;
      else begin
        @(negedge clk);
        t++;
      end
    end
    check("b2b first_latency", 64'(t), 64'(TX_CYCLES));
    check("b2b gap_tx", 64'(TX), 64'd1);
    check("b2b gap_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("b2b restart_tx", 64'(TX), 64'd0);
    check("b2b restart_busy", 64'(busy), 64'd1);
    start = 1'b0;
    finish_tx("b2b second", 0);
    check_stream("b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
